// File: rtl/cpu_memory_arbiter_if.sv
// Requester-side handshake and memory port A bus for cpu_memory_arbiter.
// slave = arbiter view, master = requesters plus memory view.
interface cpu_memory_arbiter_if #(
  parameter int NREQ   = 3,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        we;
  logic [NREQ*ADDR_W-1:0] addr;
  logic [NREQ*DATA_W-1:0] wdata;
  logic [NREQ-1:0]        ack;
  logic [NREQ-1:0]        err;
  logic [DATA_W-1:0]      rdata;
  logic                   mem_en;
  logic                   mem_write;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_wdata;
  logic [DATA_W-1:0]      mem_rdata;

  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output ack, err, rdata, mem_en, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  ack, err, rdata, mem_en, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cpu_memory_arbiter.sv
// Shares memory port A between NREQ requesters (round-robin or fixed priority)
// and refuses writes below PROTECT_TOP, flagging them with err alongside ack.
module cpu_memory_arbiter #(
  parameter int NREQ        = 3,
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 8,
  parameter int PROTECT_TOP = 512,
  parameter int RR          = 1
) (
  input logic                clk,
  input logic                reset_n,
  cpu_memory_arbiter_if.slave bus
);
  localparam int          GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NR = NREQ;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state;
  logic [GW-1:0]     grant;
  logic [GW-1:0]     last_grant;
  logic              err_pend;
  logic [GW-1:0]     win;
  logic [GW-1:0]     cand;
  logic              found;
  int unsigned       idx;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;
  logic              sel_prot;
  logic [NREQ-1:0]   grant_oh;

  // Winner search: RR starts one past the last grant, fixed mode from index 0.
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < NR; k++) begin
      if (RR != 0) idx = (32'(last_grant) + k + 1) % NR;
      else         idx = k;
      cand = GW'(idx);
      if (!found && bus.req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  assign sel_addr  = bus.addr[win*ADDR_W +: ADDR_W];
  assign sel_wdata = bus.wdata[win*DATA_W +: DATA_W];
  assign sel_we    = bus.we[win];
  assign sel_prot  = sel_we && (32'(sel_addr) < 32'(PROTECT_TOP));
  assign grant_oh  = {{(NREQ-1){1'b0}}, 1'b1} << grant;
  assign bus.rdata = bus.mem_rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      grant         <= '0;
      last_grant    <= GW'(NREQ-1);
      err_pend      <= 1'b0;
      bus.ack       <= '0;
      bus.err       <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            grant         <= win;
            bus.mem_addr  <= sel_addr;
            bus.mem_wdata <= sel_wdata;
            bus.mem_en    <= !sel_prot;
            bus.mem_write <= sel_we && !sel_prot;
            err_pend      <= sel_prot;
            state         <= ACCESS;
          end
        end
        ACCESS: begin
          bus.mem_en    <= 1'b0;
          bus.mem_write <= 1'b0;
          bus.ack       <= grant_oh;
          bus.err       <= err_pend ? grant_oh : '0;
          state         <= RESP;
        end
        RESP: begin
          bus.ack    <= '0;
          bus.err    <= '0;
          last_grant <= grant;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_memory_arbiter.sv
// Directed bench: round-robin and fixed-priority arbiters, each on its own memory model.
module tb_cpu_memory_arbiter;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pre_we = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [7:0]  pre_data = '0;
  logic [7:0]  mem_rr [0:4095];
  logic [7:0]  mem_fx [0:4095];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_memory_arbiter_if #(.NREQ(3), .ADDR_W(12), .DATA_W(8)) bus_rr ();
  cpu_memory_arbiter_if #(.NREQ(3), .ADDR_W(12), .DATA_W(8)) bus_fx ();

  cpu_memory_arbiter #(.NREQ(3), .ADDR_W(12), .DATA_W(8), .PROTECT_TOP(512), .RR(1))
    u_rr (.clk(clk), .reset_n(reset_n), .bus(bus_rr));
  cpu_memory_arbiter #(.NREQ(3), .ADDR_W(12), .DATA_W(8), .PROTECT_TOP(512), .RR(0))
    u_fx (.clk(clk), .reset_n(reset_n), .bus(bus_fx));

  // Port A memory: registered read, old contents returned on write.
  always @(posedge clk) begin
    if (pre_we) begin
      mem_rr[pre_addr] <= pre_data;
      mem_fx[pre_addr] <= pre_data;
    end else begin
      if (bus_rr.mem_en) begin
        bus_rr.mem_rdata <= mem_rr[bus_rr.mem_addr];
        if (bus_rr.mem_write) mem_rr[bus_rr.mem_addr] <= bus_rr.mem_wdata;
      end
      if (bus_fx.mem_en) begin
        bus_fx.mem_rdata <= mem_fx[bus_fx.mem_addr];
        if (bus_fx.mem_write) mem_fx[bus_fx.mem_addr] <= bus_fx.mem_wdata;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [11:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    step();
    pre_we = 1'b0;
  endtask

  // One complete access by requester r on the round-robin instance.
  task automatic xfer(input int r, input logic w, input logic [11:0] a, input logic [7:0] d,
                      input logic exp_en, input logic [7:0] exp_rd, input string tag);
    logic [2:0] oh;
    oh = 3'b001 << r;
    bus_rr.req[r] = 1'b1;
    bus_rr.we[r] = w;
    bus_rr.addr[r*12 +: 12] = a;
    bus_rr.wdata[r*8 +: 8] = d;
    step();
    check({tag, ".acc_en"}, 32'(bus_rr.mem_en), 32'(exp_en));
    check({tag, ".acc_wr"}, 32'(bus_rr.mem_write), 32'(w & exp_en));
    check({tag, ".acc_addr"}, 32'(bus_rr.mem_addr), 32'(a));
    check({tag, ".acc_ack"}, 32'(bus_rr.ack), 32'(0));
    step();
    check({tag, ".rsp_ack"}, 32'(bus_rr.ack), 32'(oh));
    check({tag, ".rsp_err"}, 32'(bus_rr.err), exp_en ? 32'(0) : 32'(oh));
    check({tag, ".rsp_en"}, 32'(bus_rr.mem_en), 32'(0));
    if (exp_en) check({tag, ".rdata"}, 32'(bus_rr.rdata), 32'(exp_rd));
    bus_rr.req[r] = 1'b0;
    bus_rr.we[r] = 1'b0;
    step();
    check({tag, ".idle_ack"}, 32'(bus_rr.ack), 32'(0));
    check({tag, ".idle_err"}, 32'(bus_rr.err), 32'(0));
  endtask

  initial begin
    bus_rr.req = '0; bus_rr.we = '0; bus_rr.addr = '0; bus_rr.wdata = '0;
    bus_fx.req = '0; bus_fx.we = '0; bus_fx.addr = '0; bus_fx.wdata = '0;
    #2;
    check("rst.ack", 32'(bus_rr.ack), 32'(0));
    check("rst.err", 32'(bus_rr.err), 32'(0));
    check("rst.en", 32'(bus_rr.mem_en), 32'(0));
    check("rst.wr", 32'(bus_rr.mem_write), 32'(0));
    check("rst.addr", 32'(bus_rr.mem_addr), 32'(0));
    check("rst.wdata", 32'(bus_rr.mem_wdata), 32'(0));
    check("rst.fx_en", 32'(bus_fx.mem_en), 32'(0));

    preload(12'h200, 8'h6A);
    preload(12'h300, 8'h11);
    preload(12'h1FF, 8'hA5);
    preload(12'h210, 8'h01);
    preload(12'h220, 8'h02);
    preload(12'h230, 8'h03);
    preload(12'h400, 8'h99);
    preload(12'h100, 8'hC3);
    preload(12'h250, 8'h44);
    preload(12'h260, 8'h55);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // T1 .. T3 and the protect boundary
    xfer(1, 1'b0, 12'h200, 8'h00, 1'b1, 8'h6A, "t1");
    xfer(0, 1'b1, 12'h300, 8'h3C, 1'b1, 8'h11, "t2w");
    xfer(0, 1'b0, 12'h300, 8'h00, 1'b1, 8'h3C, "t2r");
    xfer(1, 1'b1, 12'h1FF, 8'h55, 1'b0, 8'h00, "t3");
    check("t3.mem", 32'(mem_rr[12'h1FF]), 32'h0A5);
    xfer(2, 1'b1, 12'h200, 8'h5A, 1'b1, 8'h6A, "bnd");
    check("bnd.mem", 32'(mem_rr[12'h200]), 32'h05A);

    // T4: all three held; last grant was 2, so order is 0,1,2,0,1,2
    bus_rr.addr = {12'h230, 12'h220, 12'h210};
    bus_rr.we = '0;
    bus_rr.req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      step();
      check("t4.acc_ack", 32'(bus_rr.ack), 32'(0));
      check("t4.acc_addr", 32'(bus_rr.mem_addr), 32'h210 + 32'((k % 3) * 'h10));
      step();
      check("t4.grant", 32'(bus_rr.ack), 32'(3'b001 << (k % 3)));
      check("t4.rdata", 32'(bus_rr.rdata), 32'(k % 3 + 1));
      step();
      check("t4.idle_ack", 32'(bus_rr.ack), 32'(0));
    end
    bus_rr.req = '0;

    // T5: fixed priority, index 0 starves index 2 until it drops
    bus_fx.addr = {12'h260, 12'h000, 12'h250};
    bus_fx.req = 3'b101;
    for (int k = 0; k < 10; k++) begin
      step();
      check("t5.acc_addr", 32'(bus_fx.mem_addr), 32'h250);
      step();
      check("t5.ack0", 32'(bus_fx.ack), 32'(3'b001));
      check("t5.rdata0", 32'(bus_fx.rdata), 32'h44);
      if (k == 9) bus_fx.req[0] = 1'b0;
      step();
    end
    step();
    step();
    check("t5.ack2", 32'(bus_fx.ack), 32'(3'b100));
    check("t5.rdata2", 32'(bus_fx.rdata), 32'h55);
    bus_fx.req = '0;
    step();

    // T6: grant 0 first so a surviving last_grant would favour requester 1
    xfer(0, 1'b0, 12'h100, 8'h00, 1'b1, 8'hC3, "t6pre");
    bus_rr.req[0] = 1'b1;
    bus_rr.we[0] = 1'b1;
    bus_rr.addr[11:0] = 12'h400;
    bus_rr.wdata[7:0] = 8'h77;
    step();
    check("t6.acc_en", 32'(bus_rr.mem_en), 32'(1));
    #2;
    reset_n = 1'b0;
    #1;
    check("t6.rst_en", 32'(bus_rr.mem_en), 32'(0));
    check("t6.rst_wr", 32'(bus_rr.mem_write), 32'(0));
    check("t6.rst_ack", 32'(bus_rr.ack), 32'(0));
    bus_rr.req = '0;
    bus_rr.we = '0;
    step();
    check("t6.held_ack", 32'(bus_rr.ack), 32'(0));
    check("t6.mem", 32'(mem_rr[12'h400]), 32'h099);
    @(negedge clk);
    reset_n = 1'b1;
    bus_rr.addr = {12'h230, 12'h220, 12'h210};
    bus_rr.req = 3'b111;
    step();
    check("t6.post_en", 32'(bus_rr.mem_en), 32'(1));
    check("t6.post_addr", 32'(bus_rr.mem_addr), 32'h210);
    step();
    check("t6.post_ack", 32'(bus_rr.ack), 32'(3'b001));
    check("t6.post_rdata", 32'(bus_rr.rdata), 32'h01);
    bus_rr.req = '0;
    step();
    check("t6.post_idle", 32'(bus_rr.ack), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
